frame_serializer: RTL

Upstream feeder for the synchronous FIFO. It accepts one wide multichannel frame per handshake: NCH samples of DW bits each, plus a per-channel enable mask. It emits the enabled channels one beat at a time on an AXI-Stream output, tagging each beat with tid = channel index + TID_BASE and marking the last beat with tlast. The output is fully registered, and back-to-back frames sustain one beat per cycle.

---
 rtl/frame_serializer_pkg.sv | 16 +
 rtl/lsb_prio_enc.sv | 18 +
 rtl/frame_serializer.sv | 76 +++++++
 3 files changed

// File: rtl/frame_serializer_pkg.sv
// Shared stream helpers: lowest-set-bit index and one-hot test on channel masks.
// Masks are zero-extended to MAX_CH so one function serves every channel count.
package frame_serializer_pkg;
  localparam int MAX_CH = 256;
  localparam int MAX_IW = 8;

  function automatic logic [MAX_IW-1:0] lsb_index(input logic [MAX_CH-1:0] mask);
    lsb_index = '0;
    for (int i = MAX_CH - 1; i >= 0; i--)
      if (mask[i]) lsb_index = MAX_IW'(i);
  endfunction

  function automatic logic onehot(input logic [MAX_CH-1:0] mask);
    onehot = (mask != '0) && ((mask & (mask - MAX_CH'(1))) == '0);
  endfunction
endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder; index is meaningful only while valid is high.
module lsb_prio_enc
  import frame_serializer_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  mask,
  output logic          valid,
  output logic [IW-1:0] index
);
  if (W > MAX_CH) begin : g_too_wide
    $error("lsb_prio_enc: W exceeds MAX_CH");
  end

  assign valid = |mask;
  assign index = IW'(lsb_index(MAX_CH'(mask)));
endmodule

// File: rtl/frame_serializer.sv
// Serializes one NCH-channel frame per handshake into AXI-Stream beats of the
// enabled channels, ascending index, with a fully registered output stage.
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int DW       = 24,
  parameter int NCH      = 8,
  parameter int TIDW     = 8,
  parameter int TID_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] s_axis_tdata,
  input  logic [NCH-1:0]    s_axis_tmask,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DW-1:0]     m_axis_tdata,
  output logic [TIDW-1:0]   m_axis_tid,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  if (TID_BASE + NCH > 2**TIDW) begin : g_bad_tid
    $error("frame_serializer: TID_BASE + NCH does not fit in TIDW bits");
  end

  logic [NCH-1:0][DW-1:0] frame_q;
  logic [NCH-1:0]         pend_q;
  logic [NCH-1:0]         pend_clr;
  logic [IW-1:0]          idx;
  logic                   busy, slot_free, emit, accept, last;

  lsb_prio_enc #(.W(NCH), .IW(IW)) u_enc (
    .mask  (pend_q),
    .valid (busy),
    .index (idx)
  );

  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign emit      = busy && slot_free;
  assign pend_clr  = pend_q & ~(NCH'(1) << idx);
  assign last      = (pend_clr == '0);

  // Refill on the same cycle the final pending channel leaves, so frames butt up.
  assign s_axis_tready = rst && ((pend_q == '0) || (onehot(MAX_CH'(pend_q)) && slot_free));
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q       <= '0;
      pend_q        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (emit) begin
        m_axis_tdata  <= frame_q[idx];
        m_axis_tid    <= TIDW'(TID_BASE + int'(idx));
        m_axis_tlast  <= last;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (accept) begin
        frame_q <= s_axis_tdata;
        pend_q  <= s_axis_tmask;
      end else if (emit) begin
        pend_q  <= pend_clr;
      end
    end
  end
endmodule
